// File: rtl/pmem_arbiter.sv
`default_nettype none
// pmem_arbiter: two-requester (I/D cache) arbiter onto one physical-memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties (default: D wins). Rev 1.0
module pmem_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    logic [1:0]   state;
    logic [1:0]   next_state;
    logic [31:0]  lat_addr;
    logic [255:0] lat_wdata;
    logic         lat_write;
    logic         d_req;
    logic         grant_d;
    logic         grant_i;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // On a tie, D wins only if I was granted last.
    assign grant_d = d_req & (~i_pmem_read | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_d <= 1'b1;
            end else if (grant_i) begin
                last_d <= 1'b0;
            end
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign grant_i = i_pmem_read & ~grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = D_BUSY;
                end else if (grant_i) begin
                    next_state = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command is captured at grant so requester changes mid-transaction are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= 32'd0;
            lat_wdata <= 256'd0;
            lat_write <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                lat_addr  <= d_pmem_address;
                lat_wdata <= d_pmem_wdata;
                lat_write <= d_pmem_write;
            end else if (grant_i) begin
                lat_addr  <= i_pmem_address;
                lat_wdata <= 256'd0;
                lat_write <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'd0;
        mem_wdata   = 256'd0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state)
            I_BUSY: begin
                mem_read    = 1'b1;
                mem_address = lat_addr;
                mem_wdata   = lat_wdata;
                i_pmem_resp = mem_resp;
            end
            D_BUSY: begin
                mem_read    = ~lat_write;
                mem_write   = lat_write;
                mem_address = lat_addr;
                mem_wdata   = lat_wdata;
                d_pmem_resp = mem_resp;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule
`default_nettype wire
